// File: rtl/rv32_dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_dmem_responder_if
//  Purpose  : Request/response bundle between the load/store unit (master)
//             and the data-memory responder (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface rv32_dmem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/rv32_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_dmem_responder
//  Purpose  : Single-outstanding data-memory target with DEPTH x 32-bit
//             storage, programmable wait states, byte-enabled stores and an
//             out-of-range error response.
//  Revision : 1.0  initial release
// ============================================================================
module rv32_dmem_responder #(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  wire logic                 clk,
  input  wire logic                 RN,
  rv32_dmem_responder_if.slave      bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Full-width depth so the range check sees every address bit (no aliasing).
  localparam logic [ADDR_W:0] c_depth_ext = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      c_lat_m1    = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              commit;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [3:0]        cur_be;
  logic              in_range;
  logic [IDX_W-1:0]  cur_idx;
  logic [31:0]       mem_rd;
  logic [31:0]       merged;
  logic              mem_we;

  // Ready only in IDLE and never while reset is held.
  assign bus.req_ready = (state_q == S_IDLE) && !RN;
  assign accept        = bus.req_valid && bus.req_ready;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // Zero-latency commits happen on the acceptance edge, so the live bus is
  // used; otherwise the latched copy is used.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
      cur_be    = bus.req_be;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
    in_range = ({1'b0, cur_addr} < c_depth_ext);
    cur_idx  = cur_addr[IDX_W-1:0];
    mem_rd   = mem[cur_idx];
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = cur_be[b] ? cur_wdata[8*b +: 8] : mem_rd[8*b +: 8];
    end
  end

  // Next-state, request latch and response computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    commit      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          if (LATENCY == 0) begin
            commit  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = c_lat_m1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      rsp_valid_d = 1'b1;
      if (in_range) begin
        rsp_err_d   = 1'b0;
        rsp_rdata_d = cur_we ? 32'd0 : mem_rd;
      end else begin
        rsp_err_d   = 1'b1;
        rsp_rdata_d = 32'd0;
      end
    end
  end

  assign mem_we = commit && cur_we && in_range;

  // Control and response registers with asynchronous reset.
  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage keeps its contents across reset; commits cannot occur in reset
  // because the FSM is held in IDLE with req_ready low.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cur_idx] <= merged;
    end
  end

endmodule
`default_nettype wire
